// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported synchronous memory between instruction fetch (IF)
// and the data-memory stage (D) of the pipeline. Each cycle a winner is
// chosen: data has priority, unless fetch has been passed over STARVE_LIMIT
// times in a row. The grant drives the memory port combinationally. A latency
// counter then sequences the access. Store data is replicated across the
// big-endian byte lanes. Returned loads are lane-extracted and sign- or
// zero-extended.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   if_req/if_addr             fetch request (word address = if_addr[31:2])
//   if_gnt/if_valid/if_rdata   fetch grant, completion pulse, fetched word
//   d_req/d_we/d_addr/d_wdata  data request, store flag, byte address, data
//   d_byte/d_halfword          access size (neither set = word)
//   d_signextend               sign-extend sub-word loads
//   d_sc_mask                  failed store-conditional: suppress the write
//   d_gnt/d_valid/d_rdata      data grant, completion pulse, extended load
//   mem_en/mem_be/mem_addr     memory port strobe, byte enables, word addr
//   mem_wdata/mem_rdata        memory write data / read data
//   stall_if/stall_mem         requester has an access outstanding

// Protocol checker: requests stay up until their completion pulse, and at
// most one requester is granted per cycle.
module mem_port_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic if_req,
  input logic if_valid,
  input logic d_req,
  input logic d_valid,
  input logic if_gnt,
  input logic d_gnt
);

  a_if_req_held: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_valid) |=> (if_req || if_valid));

  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    (d_req && !d_valid) |=> (d_req || d_valid));

  a_single_grant: assert property (@(posedge clk) disable iff (rst)
    !(if_gnt && d_gnt));

endmodule

module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_byte,
  input  logic        d_halfword,
  input  logic        d_signextend,
  input  logic        d_sc_mask,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Byte enables for a store; byte lane 0 of the address is bits [31:24].
  function automatic logic [3:0] store_be(input logic [1:0] lo,
                                          input logic       is_byte,
                                          input logic       is_half);
    logic [3:0] be;
    if (is_byte) begin
      be = 4'b1000 >> lo;
    end else if (is_half) begin
      be = lo[1] ? 4'b0011 : 4'b1100;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Right-aligned store data replicated onto every lane it could occupy.
  function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                             input logic        is_byte,
                                             input logic        is_half);
    logic [31:0] data;
    if (is_byte) begin
      data = {4{wdata[7:0]}};
    end else if (is_half) begin
      data = {2{wdata[15:0]}};
    end else begin
      data = wdata;
    end
    return data;
  endfunction

  // Pick the addressed big-endian lane out of a word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rd,
                                               input logic [1:0]  lo,
                                               input logic        is_byte,
                                               input logic        is_half,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = lo[1] ? rd[15:0] : rd[31:16];
    if (is_byte) begin
      r = {{24{sext & b[7]}}, b};
    end else if (is_half) begin
      r = {{16{sext & h[15]}}, h};
    end else begin
      r = rd;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        own_data_q, own_data_d;   // 1: data stage owns the access
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        byte_q, byte_d;
  logic        half_q, half_d;
  logic        sext_q, sext_d;
  logic        we_q, we_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        busy_done_s;
  logic        can_grant_s;
  logic        starved_s;
  logic        gnt_if_s;
  logic        gnt_d_s;
  logic        unused_s;

  // The last BUSY cycle is also a grant slot so accesses can run back-to-back.
  assign busy_done_s = (state_q == ST_BUSY) && (lat_cnt_q == 4'd0);
  assign can_grant_s = !rst && ((state_q == ST_IDLE) || busy_done_s);
  assign starved_s   = (starve_cnt_q == STARVE_MAX);
  assign unused_s    = ^if_addr[1:0];

  // Winner selection: data first, fetch when starved or data is idle.
  always_comb begin
    gnt_if_s = 1'b0;
    gnt_d_s  = 1'b0;
    if (can_grant_s) begin
      if (if_req && (starved_s || !d_req)) begin
        gnt_if_s = 1'b1;
      end else if (d_req) begin
        gnt_d_s = 1'b1;
      end else begin
        gnt_if_s = 1'b0;
        gnt_d_s  = 1'b0;
      end
    end else begin
      gnt_if_s = 1'b0;
      gnt_d_s  = 1'b0;
    end
  end

  // Memory port drive in the grant cycle; quiet otherwise.
  always_comb begin
    mem_en    = gnt_if_s | gnt_d_s;
    mem_addr  = 30'd0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    if (gnt_d_s) begin
      mem_addr = d_addr[31:2];
      if (d_we) begin
        mem_wdata = store_data(d_wdata, d_byte, d_halfword);
        // A failed SC still occupies the port but writes nothing.
        mem_be    = d_sc_mask ? 4'b0000
                              : store_be(d_addr[1:0], d_byte, d_halfword);
      end else begin
        mem_wdata = 32'd0;
        mem_be    = 4'b0000;
      end
    end else if (gnt_if_s) begin
      mem_addr = if_addr[31:2];
    end else begin
      mem_addr = 30'd0;
    end
  end

  // Access sequencing: latency countdown and latching of the winner's attributes.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    own_data_d = own_data_q;
    addr_lo_d  = addr_lo_q;
    byte_d     = byte_q;
    half_d     = half_q;
    sext_d     = sext_q;
    we_d       = we_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_if_s || gnt_d_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else if (gnt_if_s || gnt_d_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lat_cnt_d = 4'd0;
      end
    endcase
    if (gnt_d_s) begin
      lat_cnt_d  = LAT_LOAD;
      own_data_d = 1'b1;
      addr_lo_d  = d_addr[1:0];
      byte_d     = d_byte;
      half_d     = d_halfword;
      sext_d     = d_signextend;
      we_d       = d_we;
    end else if (gnt_if_s) begin
      lat_cnt_d  = LAT_LOAD;
      own_data_d = 1'b0;
      addr_lo_d  = 2'd0;
      byte_d     = 1'b0;
      half_d     = 1'b0;
      sext_d     = 1'b0;
      we_d       = 1'b0;
    end else begin
      own_data_d = own_data_q;
    end
  end

  // Starvation guard: counts data wins over a waiting fetch.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt_if_s) begin
      starve_cnt_d = 4'd0;
    end else if (gnt_d_s && if_req && !starved_s) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Completion pulses are registered: they fire in the cycle the countdown
  // reaches zero, which is also when the memory presents the read word.
  always_comb begin
    if_valid_d = (state_d == ST_BUSY) && (lat_cnt_d == 4'd0) && !own_data_d;
    d_valid_d  = (state_d == ST_BUSY) && (lat_cnt_d == 4'd0) &&  own_data_d;
    if (if_valid_q) begin
      if_rdata_d = mem_rdata;
    end else begin
      if_rdata_d = if_rdata_q;
    end
    if (d_valid_q && !we_q) begin
      d_rdata_d = load_extract(mem_rdata, addr_lo_q, byte_q, half_q, sext_q);
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      own_data_q   <= 1'b0;
      addr_lo_q    <= 2'd0;
      byte_q       <= 1'b0;
      half_q       <= 1'b0;
      sext_q       <= 1'b0;
      we_q         <= 1'b0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      own_data_q   <= own_data_d;
      addr_lo_q    <= addr_lo_d;
      byte_q       <= byte_d;
      half_q       <= half_d;
      sext_q       <= sext_d;
      we_q         <= we_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Read data passes straight through in the completion cycle and is held
  // from the register afterwards.
  assign if_gnt    = gnt_if_s;
  assign d_gnt     = gnt_d_s;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_d;
  assign d_rdata   = d_rdata_d;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

  mem_port_arbiter_checker u_checker (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_valid (if_valid_q),
    .d_req    (d_req),
    .d_valid  (d_valid_q),
    .if_gnt   (gnt_if_s),
    .d_gnt    (gnt_d_s)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_byte, d_halfword, d_signextend, d_sc_mask;
  logic        d_gnt, d_valid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte(d_byte), .d_halfword(d_halfword), .d_signextend(d_signextend),
    .d_sc_mask(d_sc_mask), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  sel;    // {if_gnt, d_gnt}
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    logic        chk;
    logic [31:0] data;
  } val_exp_t;

  gnt_exp_t gnt_q[$];
  val_exp_t dv_q[$];
  val_exp_t iv_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: read word appears LAT cycles after mem_en.
  logic [31:0] mem_words [logic [29:0]];
  logic [31:0] rd_pipe [LAT];

  function automatic logic [31:0] mem_read(input logic [29:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? mem_read(mem_addr) : 32'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Monitor: pops expectations whenever the DUT grants or completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || d_gnt) begin
        if (gnt_q.size() == 0) begin
          check("unexpected_grant", {30'd0, if_gnt, d_gnt}, 32'd0);
        end else begin
          gnt_exp_t g;
          g = gnt_q.pop_front();
          check("gnt_cycle", 32'(cyc), 32'(g.cyc));
          check("gnt_sel", {30'd0, if_gnt, d_gnt}, {30'd0, g.sel});
          check("mem_en", {31'd0, mem_en}, 32'd1);
          check("mem_addr", {2'd0, mem_addr}, {2'd0, g.addr});
          check("mem_be", {28'd0, mem_be}, {28'd0, g.be});
          check("mem_wdata", mem_wdata, g.wdata);
        end
      end
      if (d_valid) begin
        if (dv_q.size() == 0) begin
          check("unexpected_d_valid", 32'd1, 32'd0);
        end else begin
          val_exp_t v;
          v = dv_q.pop_front();
          check("d_valid_cycle", 32'(cyc), 32'(v.cyc));
          if (v.chk) check("d_rdata", d_rdata, v.data);
        end
      end
      if (if_valid) begin
        if (iv_q.size() == 0) begin
          check("unexpected_if_valid", 32'd1, 32'd0);
        end else begin
          val_exp_t v;
          v = iv_q.pop_front();
          check("if_valid_cycle", 32'(cyc), 32'(v.cyc));
          check("if_rdata", if_rdata, v.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    d_byte = 1'b0; d_halfword = 1'b0; d_signextend = 1'b0; d_sc_mask = 1'b0;
  endtask

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input int c, input logic [1:0] sel, input logic [29:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    gnt_exp_t g;
    g.cyc = c; g.sel = sel; g.addr = a; g.be = be; g.wdata = wd;
    gnt_q.push_back(g);
  endtask

  task automatic push_val(input logic is_if, input int c, input logic chk, input logic [31:0] d);
    val_exp_t v;
    v.cyc = c; v.chk = chk; v.data = d;
    if (is_if) iv_q.push_back(v);
    else dv_q.push_back(v);
  endtask

  // One isolated data access starting in the current (idle) cycle.
  task automatic data_access(input string nm, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic bt, input logic hw,
                             input logic sx, input logic sc, input logic [31:0] word,
                             input logic [31:0] exp_rd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd);
    mem_words[addr[31:2]] = word;
    push_gnt(cyc, 2'b01, addr[31:2], exp_be, exp_wd);
    push_val(1'b0, cyc + LAT, !we, exp_rd);
    d_we = we; d_addr = addr; d_wdata = wdata; d_byte = bt; d_halfword = hw;
    d_signextend = sx; d_sc_mask = sc; d_req = 1'b1;
    #1;
    check({nm, "_stall_mem_wait"}, {31'd0, stall_mem}, 32'd1);
    next_cycle(LAT);
    check({nm, "_stall_mem_done"}, {31'd0, stall_mem}, 32'd0);
    idle_inputs();
    next_cycle(1);
    if (!we) check({nm, "_d_rdata_hold"}, d_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    idle_inputs();
    next_cycle(3);

    // Reset state
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;

    // Loads from word 0x12803456 and 0x8001FFFE
    data_access("lb_101",  1'b0, 32'h101, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12803456, 32'hFFFFFF80, 4'b0000, 32'h0);
    data_access("lbu_101", 1'b0, 32'h101, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12803456, 32'h00000080, 4'b0000, 32'h0);
    data_access("lh_102",  1'b0, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h12803456, 32'h00003456, 4'b0000, 32'h0);
    data_access("lh_100",  1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h12803456, 32'h00001280, 4'b0000, 32'h0);
    data_access("lb_100",  1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12803456, 32'h00000012, 4'b0000, 32'h0);
    data_access("lb_103",  1'b0, 32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12803456, 32'h00000056, 4'b0000, 32'h0);
    data_access("lh_110",  1'b0, 32'h110, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8001FFFE, 32'hFFFF8001, 4'b0000, 32'h0);
    data_access("lhu_112", 1'b0, 32'h112, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8001FFFE, 32'h0000FFFE, 4'b0000, 32'h0);
    data_access("lh_112",  1'b0, 32'h112, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8001FFFE, 32'hFFFFFFFE, 4'b0000, 32'h0);
    data_access("lw_114",  1'b0, 32'h114, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h89ABCDEF, 32'h89ABCDEF, 4'b0000, 32'h0);

    // Stores: lane enables and replicated data
    data_access("sb_103", 1'b1, 32'h103, 32'h000000AB, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0001, 32'hABABABAB);
    data_access("sb_100", 1'b1, 32'h100, 32'h000000CD, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1000, 32'hCDCDCDCD);
    data_access("sh_102", 1'b1, 32'h102, 32'h00001234, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0011, 32'h12341234);
    data_access("sh_100", 1'b1, 32'h100, 32'h00005678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1100, 32'h56785678);
    data_access("sw_108", 1'b1, 32'h108, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111, 32'h89ABCDEF);
    // Failed SC: port still used, no byte enables, completion still pulses
    data_access("sc_120", 1'b1, 32'h120, 32'h00000055, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h00000055);

    // Simultaneous fetch and LW 0x100: data first, fetch regranted at completion
    t = cyc;
    mem_words[30'h40]  = 32'h11223344;
    mem_words[30'h100] = 32'hDEADBEEF;
    push_gnt(t, 2'b01, 30'h40, 4'b0000, 32'h0);
    push_val(1'b0, t + LAT, 1'b1, 32'h11223344);
    push_gnt(t + LAT, 2'b10, 30'h100, 4'b0000, 32'h0);
    push_val(1'b1, t + 2*LAT, 1'b1, 32'hDEADBEEF);
    d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
    if_addr = 32'h400; if_req = 1'b1;
    #1;
    check("both_stall_if", {31'd0, stall_if}, 32'd1);
    check("both_stall_mem", {31'd0, stall_mem}, 32'd1);
    next_cycle(LAT);
    d_req = 1'b0;
    #1;
    check("both_stall_if_wait", {31'd0, stall_if}, 32'd1);
    next_cycle(LAT);
    check("both_stall_if_done", {31'd0, stall_if}, 32'd0);
    idle_inputs();
    next_cycle(1);

    // Starvation: data held back-to-back, fetch wins after STARVE data grants,
    // then the cleared counter lets data win the next slot again.
    t = cyc;
    mem_words[30'h80] = 32'hA5A50001;
    mem_words[30'hC0] = 32'h0BADC0DE;
    for (int k = 0; k < STARVE; k++) begin
      push_gnt(t + k*LAT, 2'b01, 30'h80, 4'b0000, 32'h0);
      push_val(1'b0, t + (k+1)*LAT, 1'b1, 32'hA5A50001);
    end
    push_gnt(t + STARVE*LAT, 2'b10, 30'hC0, 4'b0000, 32'h0);
    push_val(1'b1, t + (STARVE+1)*LAT, 1'b1, 32'h0BADC0DE);
    push_gnt(t + (STARVE+1)*LAT, 2'b01, 30'h80, 4'b0000, 32'h0);
    push_val(1'b0, t + (STARVE+2)*LAT, 1'b1, 32'hA5A50001);
    push_gnt(t + (STARVE+2)*LAT, 2'b10, 30'hC0, 4'b0000, 32'h0);
    push_val(1'b1, t + (STARVE+3)*LAT, 1'b1, 32'h0BADC0DE);
    d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    next_cycle((STARVE+2)*LAT);
    d_req = 1'b0;
    next_cycle(LAT);
    idle_inputs();
    next_cycle(1);

    // Reset in the cycle after a grant discards the access
    push_gnt(cyc, 2'b01, 30'h80, 4'b0000, 32'h0);
    d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
    next_cycle(1);
    rst = 1'b1;
    idle_inputs();
    #1;
    check("midrst_d_valid", {31'd0, d_valid}, 32'd0);
    check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    check("midrst_d_rdata", d_rdata, 32'd0);
    check("midrst_if_rdata", if_rdata, 32'd0);
    next_cycle(LAT);
    check("midrst_valids_late", {30'd0, if_valid, d_valid}, 32'd0);
    check("midrst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
    rst = 1'b0;
    data_access("lw_after_rst", 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000, 32'h0);
    next_cycle(2);

    check("gnt_q_left", 32'(gnt_q.size()), 32'd0);
    check("dv_q_left", 32'(dv_q.size()), 32'd0);
    check("iv_q_left", 32'(iv_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
